// File: rtl/bsram_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port BSRAM between a loader (A) and
// the convolution engine (B), with bounded bursts and per-port routing of read returns.
module bsram_arbiter #(
    parameter int unsigned AW        = 14,
    parameter int unsigned DW        = 12,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_ce,
    output logic          mem_wre,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          mem_rst,
    output logic          owner,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

    localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

    state_e     state_q, state_d;
    logic       rr_q, rr_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       owner_q, owner_d;
    logic       busy_q;
    logic       a_pend_q, b_pend_q;
    logic       a_win, b_win;
    logic       below_limit;

    assign below_limit = beat_cnt_q < MaxBurst;

    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        case (state_q)
            StIdle: begin
                if (a_req && b_req) begin
                    a_win = ~rr_q;
                    b_win = rr_q;
                end else begin
                    a_win = a_req;
                    b_win = b_req;
                end
            end
            StOwnA: begin
                if (a_req && (below_limit || !b_req)) a_win = 1'b1;
                else                                  b_win = b_req;
            end
            StOwnB: begin
                if (b_req && (below_limit || !a_req)) b_win = 1'b1;
                else                                  a_win = a_req;
            end
            default: ;
        endcase
    end

    // Grants are forced low while reset is asserted, whatever the requests do.
    assign a_gnt = a_win & rst;
    assign b_gnt = b_win & rst;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        beat_cnt_d = beat_cnt_q;
        owner_d    = owner_q;
        if (a_gnt) begin
            state_d = StOwnA;
            owner_d = 1'b0;
            if (state_q == StOwnA) begin
                beat_cnt_d = below_limit ? beat_cnt_q + 8'd1 : 8'd1;
            end else begin
                beat_cnt_d = 8'd1;
                if (state_q == StOwnB) rr_d = 1'b1;
            end
        end else if (b_gnt) begin
            state_d = StOwnB;
            owner_d = 1'b1;
            if (state_q == StOwnB) begin
                beat_cnt_d = below_limit ? beat_cnt_q + 8'd1 : 8'd1;
            end else begin
                beat_cnt_d = 8'd1;
                if (state_q == StOwnA) rr_d = 1'b0;
            end
        end else begin
            state_d    = StIdle;
            beat_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            beat_cnt_q <= 8'd0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            a_pend_q   <= 1'b0;
            b_pend_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            beat_cnt_q <= beat_cnt_d;
            owner_q    <= owner_d;
            busy_q     <= a_gnt | b_gnt;
            a_pend_q   <= a_gnt & ~a_we;
            b_pend_q   <= b_gnt & ~b_we;
        end
    end

    always_comb begin
        mem_ce   = a_gnt | b_gnt;
        mem_wre  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (a_gnt) begin
            mem_wre  = a_we;
            mem_addr = a_addr;
            mem_din  = a_wdata;
        end else if (b_gnt) begin
            mem_wre  = b_we;
            mem_addr = b_addr;
            mem_din  = b_wdata;
        end
    end

    assign a_rvalid = a_pend_q;
    assign b_rvalid = b_pend_q;
    assign a_rdata  = a_pend_q ? mem_dout : '0;
    assign b_rdata  = b_pend_q ? mem_dout : '0;
    assign mem_rst  = ~rst;
    assign owner    = owner_q;
    assign busy     = busy_q;

endmodule
